wb_int_ctrl: RTL

Parametrised Wishbone-slave interrupt controller that replaces the fixed OR/priority-mux interrupt logic at the SoC top level. It synchronises N_SRC raw interrupt lines, latches edge- or level-mode pending bits, applies a software mask, and drives the CPU's INT and Cause inputs from a registered priority encoder. Software reads, masks, clears and claims interrupts through four word registers on the existing Wishbone intercon.

---
 rtl/wb_int_pkg.sv | 26 ++
 rtl/int_sync_edge.sv | 29 ++
 rtl/wb_int_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_int_pkg.sv
// Shared constants and helpers for the Wishbone interrupt controller.
package wb_int_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;

    // Register offsets, decoded from ADDR[3:2]
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    // CLAIM read bit that flags "no active source"
    localparam int unsigned CLAIM_NONE_BIT = 31;

    // Lowest set index of a zero-extended vector; 0 when empty.
    function automatic logic [IDX_W-1:0] prio_enc(input logic [DATA_W-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_sync_edge.sv
// One interrupt source: multi-flop synchroniser followed by a rise detector.
module int_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic level,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q;
    logic              dly;

    // Shift the raw line through the synchroniser, then keep one delayed copy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            dly    <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly    <= sync_q[STAGES-1];
        end
    end

    assign level  = sync_q[STAGES-1];
    assign rise_c = level & ~dly;

endmodule

// File: rtl/wb_int_ctrl.sv
// Wishbone-slave interrupt controller: pending/mask/mode registers,
// claim port and a registered priority-encoded INT/CAUSE.
module wb_int_ctrl
    import wb_int_pkg::*;
#(
    parameter int unsigned      N_SRC       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0] MASK_RST    = '1,
    parameter logic [N_SRC-1:0] MODE_RST    = '1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_SRC-1:0]  src_in,
    input  logic              STB,
    input  logic              WE,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       DAT_I,
    output logic [31:0]       DAT_O,
    output logic              ACK,
    output logic              INT,
    output logic [31:0]       CAUSE
);

    logic [N_SRC-1:0]  level;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  mask;
    logic [N_SRC-1:0]  mode;
    logic [N_SRC-1:0]  active;
    logic [N_SRC-1:0]  clr;
    logic [N_SRC-1:0]  pend_next;
    logic [IDX_W-1:0]  win_idx;
    logic              any_act;
    logic              access;
    logic              wr;
    logic              rd;
    logic [1:0]        reg_sel;
    logic [DATA_W-1:0] rdata;
    logic              unused_bus;

    // Per-source synchroniser and rise detector
    for (genvar i = 0; i < int'(N_SRC); i++) begin : g_src
        int_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rstn   (rstn),
            .din    (src_in[i]),
            .level  (level[i]),
            .rise_c (rise[i])
        );
    end

    // An access is sampled once: the first STB cycle while ACK is low
    assign access  = STB & ~ACK;
    assign wr      = access & WE;
    assign rd      = access & ~WE;
    assign reg_sel = ADDR[3:2];

    assign active  = pending & mask;
    assign any_act = |active;
    assign win_idx = prio_enc(DATA_W'(active));

    assign unused_bus = ^{ADDR[31:4], ADDR[1:0], DAT_I};

    // Edge-mode clear sources (W1C and claim) and the next pending value
    always_comb begin
        clr = '0;
        if (wr && reg_sel == REG_PENDING) begin
            clr = DAT_I[N_SRC-1:0];
        end
        if (rd && reg_sel == REG_CLAIM && any_act) begin
            clr = clr | (N_SRC'(1) << win_idx);
        end
        // Set wins over clear in edge mode; level mode tracks the synced line
        pend_next = (mode & (rise | (pending & ~clr))) | (~mode & level);
    end

    // Read mux, evaluated against register state at the sampling edge
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_PENDING: rdata = DATA_W'(pending);
            REG_MASK:    rdata = DATA_W'(mask);
            REG_MODE:    rdata = DATA_W'(mode);
            default: begin
                rdata[CLAIM_NONE_BIT] = ~any_act;
                rdata[IDX_W-1:0]      = win_idx;
            end
        endcase
    end

    // Bus response, interrupt state registers and registered INT/CAUSE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ACK     <= 1'b0;
            DAT_O   <= '0;
            INT     <= 1'b0;
            CAUSE   <= '0;
            pending <= '0;
            mask    <= MASK_RST;
            mode    <= MODE_RST;
        end else begin
            ACK     <= access;
            DAT_O   <= access ? rdata : '0;
            INT     <= any_act;
            CAUSE   <= any_act ? DATA_W'(win_idx) : '0;
            pending <= pend_next;
            if (wr && reg_sel == REG_MASK) mask <= DAT_I[N_SRC-1:0];
            if (wr && reg_sel == REG_MODE) mode <= DAT_I[N_SRC-1:0];
        end
    end

endmodule
